ex_muldiv_unit: RTL

- Multi-cycle multiply/divide engine in the EX stage of the 16-bit pipelined core.
- Consumes the operands, destination register and ALU control code held in the ID/EX pipeline register.
- Drives a stall back upstream so IF/ID and ID/EX hold while it iterates.
- Delivers a one-cycle result packet toward EX/MEM.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/ex_muldiv_unit_div_restore_step.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared ALU codes, FSM states and widths for the EX-stage multiply/divide unit
package muldiv_pkg;

    localparam int DEFAULT_DATA_W = 16;

    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_MULH = 4'b1001;
    localparam logic [3:0] ALU_DIVU = 4'b1010;
    localparam logic [3:0] ALU_REMU = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The four supported codes share the 2'b10 prefix; bit 1 selects divide, bit 0 the high/remainder half.
    function automatic logic is_muldiv(input logic [3:0] code);
        return code[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_restore_step.sv
// rtl/ex_muldiv_unit_div_restore_step.sv - one combinational restoring-division iteration
module div_restore_step
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] trial;
    logic [DATA_W:0] diff;

    // Shift the next dividend bit into the partial remainder and subtract the divisor if it fits.
    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle MUL/MULH/DIVU/REMU engine with upstream stall; MULDIV_EARLY_OUT_EN enables multiply early exit
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_in,
    input  logic [3:0]        aluControl_in,
    input  logic [DATA_W-1:0] op1_in,
    input  logic [DATA_W-1:0] op2_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              regWrite_in,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [DATA_W-1:0] result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              regWrite_out,
    output logic              div_zero_out
);

    state_t state, state_nxt;

    logic [3:0]          code_q;
    logic [RD_W-1:0]     rd_q;
    logic                rw_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    // Multiplier shift register during MUL; holds the untouched divisor during DIV.
    logic [DATA_W-1:0]   mplier_q;
    // Dividend shift register that fills with quotient bits from the bottom.
    logic [DATA_W-1:0]   quot_q;
    logic [DATA_W-1:0]   rem_q;
    logic [CNT_W-1:0]    cnt_q;

    logic              accept;
    logic              last_iter;
    logic              mul_exit;
    logic              out_valid;
    logic [DATA_W-1:0] step_rem;
    logic              step_q;

    assign accept    = (state == IDLE) && start_in && is_muldiv(aluControl_in) && !flush_in && !reset;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef MULDIV_EARLY_OUT_EN
    // Stop once the multiplier shifted by this iteration has no set bits left.
    assign mul_exit = last_iter || (mplier_q[DATA_W-1:1] == '0);
`else
    assign mul_exit = last_iter;
`endif

    div_restore_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (quot_q[DATA_W-1]),
        .divisor      (mplier_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and result packet; the packet is only visible in the DONE cycle.
    always_comb begin
        state_nxt    = state;
        stall_out    = 1'b0;
        busy_out     = (state != IDLE);
        out_valid    = (state == DONE) && !flush_in && !reset;
        done_out     = 1'b0;
        result_out   = '0;
        rd_out       = '0;
        regWrite_out = 1'b0;
        div_zero_out = 1'b0;

        case (state)
            IDLE: begin
                stall_out = accept;
                if (accept) begin
                    if (op2_in == '0) begin
                        state_nxt = DONE;
                    end else if (aluControl_in[1]) begin
                        state_nxt = DIV;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL: begin
                stall_out = !reset;
                if (flush_in) begin
                    state_nxt = IDLE;
                end else if (mul_exit) begin
                    state_nxt = DONE;
                end
            end
            DIV: begin
                stall_out = !reset;
                if (flush_in) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (out_valid) begin
            done_out     = 1'b1;
            rd_out       = rd_q;
            regWrite_out = rw_q;
            div_zero_out = code_q[1] && (mplier_q == '0);
            case (code_q[1:0])
                2'b00:   result_out = acc_q[DATA_W-1:0];
                2'b01:   result_out = acc_q[2*DATA_W-1:DATA_W];
                2'b10:   result_out = quot_q;
                default: result_out = rem_q;
            endcase
        end
    end

    // Operand capture and the per-iteration multiply / divide datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q   <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        code_q   <= aluControl_in;
                        rd_q     <= rd_in;
                        rw_q     <= regWrite_in;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= {{DATA_W{1'b0}}, op1_in};
                        mplier_q <= op2_in;
                        // A zero divisor skips iteration, so preload the defined divide-by-zero answers.
                        quot_q   <= (op2_in == '0) ? '1 : op1_in;
                        rem_q    <= (op2_in == '0) ? op1_in : '0;
                    end
                end
                MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (!last_iter) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV: begin
                    rem_q  <= step_rem;
                    quot_q <= {quot_q[DATA_W-2:0], step_q};
                    if (!last_iter) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
